// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined SLL/SRL/SRA/ROL barrel shifter with valid/ready on both sides.
// Define PIPE_SHIFTER_STICKY_EN to build the sticky (shifted-out OR) path; otherwise out_sticky is 0.
module pipe_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH):0]   in_amt,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_sticky
);
    localparam int L = $clog2(WIDTH);
    localparam int Q = L / STAGES;
    localparam int R = L % STAGES;
`ifdef PIPE_SHIFTER_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic en;
    logic ovr;
    logic [WIDTH-1:0] d0;
    logic st0;

    function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] d, input logic [1:0] op, input int k);
        logic [2*WIDTH-1:0] r, l;
        r = {{WIDTH{op == 2'b11 && d[WIDTH-1]}}, d} >> k;
        l = {d, d} << k;
        return op == 2'b00 ? d << k : op == 2'b10 ? l[2*WIDTH-1:WIDTH] : r[WIDTH-1:0];
    endfunction

    function automatic logic lost(input logic [WIDTH-1:0] d, input logic [1:0] op, input int k);
        return STICKY && op[0] && |(d & ~({WIDTH{1'b1}} << k));
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    // Over-range right/left shifts collapse to the fill pattern up front; ROL ignores the top amount bit.
    assign ovr = in_amt[L] && in_op != 2'b10;
    assign d0  = ovr ? {WIDTH{in_op == 2'b11 && in_data[WIDTH-1]}} : in_data;
    assign st0 = STICKY && ovr && in_op[0] && |in_data;

    for (genvar s = 0; s < STAGES; s++) begin : stg
        localparam int LO = s * Q + (s < R ? s : R);
        localparam int HI = LO + Q + (s < R ? 1 : 0);
        logic v_i, st_i, st_n, v_q, st_q;
        logic [WIDTH-1:0] d_i, d_n, d_q;
        logic [L-LO-1:0] a_i;
        logic [1:0] op_i;
        logic [TAG_W-1:0] t_i, t_q;
        if (s == 0) begin : src
            assign v_i  = in_valid;
            assign d_i  = d0;
            assign st_i = st0;
            assign a_i  = in_amt[L-1:0];
            assign op_i = in_op;
            assign t_i  = in_tag;
        end else begin : src
            assign v_i  = stg[s-1].v_q;
            assign d_i  = stg[s-1].d_q;
            assign st_i = stg[s-1].st_q;
            assign a_i  = stg[s-1].ctl.a_q;
            assign op_i = stg[s-1].ctl.op_q;
            assign t_i  = stg[s-1].t_q;
        end
        always_comb begin
            d_n  = d_i;
            st_n = st_i;
            for (int i = 0; i < HI - LO; i++)
                if (a_i[i]) begin
                    st_n = st_n | lost(d_n, op_i, 1 << (LO + i));
                    d_n  = lvl(d_n, op_i, 1 << (LO + i));
                end
        end
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                v_q  <= 1'b0;
                d_q  <= '0;
                t_q  <= '0;
                st_q <= 1'b0;
            end else if (en) begin
                v_q  <= v_i;
                d_q  <= d_n;
                t_q  <= t_i;
                st_q <= st_n;
            end
        if (s < STAGES - 1) begin : ctl
            logic [L-HI-1:0] a_q;
            logic [1:0] op_q;
            always_ff @(posedge clk or posedge reset)
                if (reset) begin
                    a_q  <= '0;
                    op_q <= '0;
                end else if (en) begin
                    a_q  <= a_i[L-LO-1:HI-LO];
                    op_q <= op_i;
                end
        end
    end

    assign out_valid  = stg[STAGES-1].v_q;
    assign out_data   = stg[STAGES-1].d_q;
    assign out_tag    = stg[STAGES-1].t_q;
    assign out_sticky = stg[STAGES-1].st_q;
endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: random and directed checks of pipe_shifter against a plain-arithmetic shift model.
module tb_pipe_shifter;
    localparam int WIDTH = 32;
    localparam int STAGES = 2;
    localparam int TAG_W = 4;
`ifdef PIPE_SHIFTER_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_ready, out_valid, out_ready, out_sticky;
    logic [WIDTH-1:0] in_data, out_data;
    logic [5:0] in_amt;
    logic [1:0] in_op;
    logic [TAG_W-1:0] in_tag, out_tag;

    int checks = 0;
    int errors = 0;
    int n_out = 0;
    logic last_acc = 1'b0;
    logic hold_v = 1'b0;
    logic [36:0] hold;
    logic [36:0] q[$];

    pipe_shifter #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] d, input logic [5:0] a, input logic [1:0] op);
        logic [63:0] w;
        logic signed [31:0] sd;
        logic [31:0] r;
        logic s;
        s = 1'b0;
        r = d;
        case (op)
            2'b00: r = a >= 32 ? 32'h0 : d << a;
            2'b01: begin
                r = a >= 32 ? 32'h0 : d >> a;
                s = a >= 32 ? |d : |(d & ((32'h1 << a) - 32'h1));
            end
            2'b11: begin
                sd = $signed(d) >>> a[4:0];
                r  = a >= 32 ? {32{d[31]}} : sd;
                s  = a >= 32 ? |d : |(d & ((32'h1 << a) - 32'h1));
            end
            default: begin
                w = {d, d} << a[4:0];
                r = w[63:32];
            end
        endcase
        return {s & STK, r};
    endfunction

    task automatic step();
        logic [36:0] e;
        #1;
        if (hold_v) check("hold", {out_tag, out_sticky, out_data}, hold);
        hold_v = out_valid && !out_ready;
        hold = {out_tag, out_sticky, out_data};
        if (!out_ready) check("stall_rdy", in_ready, !out_valid);
        if (out_valid && out_ready) begin
            if (q.size() == 0) check("spurious", 1, 0);
            else begin
                e = q.pop_front();
                check("data", out_data, e[31:0]);
                check("sticky", out_sticky, e[32]);
                check("tag", out_tag, e[36:33]);
                n_out++;
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) q.push_back({in_tag, model(in_data, in_amt, in_op)});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic one(input logic [31:0] d, input logic [5:0] a, input logic [1:0] op,
                       input logic [3:0] t, input logic [31:0] ed, input logic es);
        int n;
        in_valid = 1'b1; in_data = d; in_amt = a; in_op = op; in_tag = t; out_ready = 1'b1;
        #1 check("acc_rdy", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("latency", n, STAGES - 1);
        check("d_data", out_data, ed);
        check("d_tag", out_tag, t);
        check("d_sticky", out_sticky, es & STK);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int sent, base, tries;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_sticky", out_sticky, 0);
        reset = 1'b0;
        @(negedge clk);

        one(32'h00000F5E, 6'd2, 2'b00, 4'd3, 32'h00003D78, 1'b0);
        one(32'h0000001B, 6'd2, 2'b01, 4'd1, 32'h00000006, 1'b1);
        one(32'h80000000, 6'd4, 2'b11, 4'd2, 32'hF8000000, 1'b0);
        one(32'h80000001, 6'd1, 2'b10, 4'd4, 32'h00000003, 1'b0);
        one(32'h12345678, 6'd40, 2'b00, 4'd5, 32'h00000000, 1'b0);
        one(32'h80000001, 6'd40, 2'b11, 4'd6, 32'hFFFFFFFF, 1'b1);
        one(32'h00000000, 6'd40, 2'b01, 4'd7, 32'h00000000, 1'b0);
        one(32'h80000001, 6'd33, 2'b10, 4'd8, 32'h00000003, 1'b0);
        one(32'hDEADBEEF, 6'd0, 2'b01, 4'd9, 32'hDEADBEEF, 1'b0);
        one(32'h40000000, 6'd63, 2'b01, 4'd10, 32'h00000000, 1'b1);

        // 8-beat stream with a 3-cycle output stall
        base = n_out;
        sent = 0;
        for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
            in_valid = sent < 8;
            in_data = $urandom;
            in_amt = 6'($urandom);
            in_op = 2'($urandom);
            in_tag = 4'(sent);
            out_ready = !(c >= 3 && c <= 5);
            step();
            sent += int'(last_acc);
        end
        check("stream_n", n_out - base, 8);
        check("stream_q", q.size(), 0);

        // reset with two beats in flight
        in_valid = 1'b1; in_data = 32'h0000_00FF; in_amt = 6'd1; in_op = 2'b00; in_tag = 4'hA; out_ready = 1'b1;
        step();
        in_tag = 4'hB;
        step();
        in_valid = 1'b0;
        check("fill_valid", out_valid, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("rst_async_valid", out_valid, 0);
        check("rst_async_data", out_data, 0);
        #4 reset = 1'b0;
        q.delete();
        hold_v = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_idle", out_valid, 0);
            step();
        end
        one(32'h0000_00F0, 6'd4, 2'b01, 4'hC, 32'h0000_000F, 1'b0);

        // all amounts x all ops, random data and random backpressure
        for (int op = 0; op < 4; op++)
            for (int a = 0; a < 64; a++) begin
                in_valid = 1'b1;
                in_data = $urandom;
                in_amt = 6'(a);
                in_op = 2'(op);
                in_tag = 4'($urandom);
                tries = 0;
                do begin
                    out_ready = $urandom_range(0, 3) != 0;
                    step();
                    tries++;
                end while (!last_acc && tries < 50);
                if (!last_acc) check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    out_ready = $urandom_range(0, 1) != 0;
                    step();
                end
            end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        check("drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
